syst_skew_feeder: RTL and testbench
===================================

Name: syst_skew_feeder

Overview:
- Input-side stage of the weight-stationary systolic array; drives the x_i inputs of the left column of syst_node instances.
- Accepts one ROWS-wide activation vector per cycle over a valid/ready handshake.
- Skews the vector diagonally: row r is delayed by r extra cycles, so the partial sums line up as they move down the columns.
- After the last vector it injects zero bubbles to drain the array, then pulses done.

Parameters:
- ROWS, 4, number of array rows (lanes); >= 1.
- COLS, 4, number of array columns; sets the drain length.
- X_WIDTH, 8, activation width per row; matches syst_node X_WIDTH.
- CNT_WIDTH, 16, width of the accepted-vector counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  feeder can accept a vector this cycle.
- in_data  in  ROWS*X_WIDTH  activation vector; row r at bits [r*X_WIDTH +: X_WIDTH].
- in_last  in  1  marks the final vector of a burst; qualified by the handshake.
- x_o  out  ROWS*X_WIDTH  skewed activations to array row inputs, same packing.
- row_valid_o  out  ROWS  bit r set when x_o row r carries real data, not a bubble.
- busy_o  out  1  high in STREAM or DRAIN.
- done_o  out  1  one-cycle pulse at the end of the drain.
- vec_cnt_o  out  CNT_WIDTH  vectors accepted in the current or most recent burst.

Behaviour:
- Reset: asserting rst_n low immediately clears all delay-line data and valid bits, the state (to IDLE), the drain counter and vec_cnt_o. Outputs then read x_o=0, row_valid_o=0, busy_o=0, done_o=0, in_ready=1, vec_cnt_o=0. A reset during STREAM or DRAIN abandons the burst; no done pulse is produced.
- Handshake:
  - accept = in_valid & in_ready.
  - in_ready = 1 in IDLE and STREAM, 0 in DRAIN.
  - in_data and in_last are ignored when accept=0.
- Delay lines:
  - Row r is a shift chain of r+1 registers, each holding {valid, data}.
  - Every cycle, stage 0 of every row loads {1, in_data row r} if accept, else {0, 0}.
  - All stages shift every cycle; there is no stall.
  - x_o row r and row_valid_o[r] come from the last stage of row r.
- Latency: a vector accepted in cycle t appears on row r at cycle t+1+r. Row 0 has latency 1 and row ROWS-1 has latency ROWS.
- Bubbles: cycles with no accept insert zero data with valid 0. Zero x gives a zero product in syst_node, so bubbles do not corrupt partial sums.
- FSM:
  - IDLE: on accept with in_last=0, go to STREAM; with in_last=1 (single-vector burst), go to DRAIN.
  - STREAM: on accept with in_last=1, go to DRAIN. Otherwise stay; gaps in in_valid are allowed.
  - DRAIN: lasts exactly DRAIN_LEN = ROWS+COLS-1 cycles, counted by a down-counter loaded on entry. done_o=1 in the final DRAIN cycle, then go to IDLE.
- Counter:
  - An accept from IDLE sets vec_cnt_o to 1.
  - Each accept in STREAM increments it, saturating at all-ones.
  - It holds its value through DRAIN and IDLE until the next burst starts.
- busy_o = (state != IDLE).
- Back-to-back bursts: the first accept of a new burst happens no earlier than the cycle after done_o.
- Boundary cases:
  - ROWS=1: a single register, no skew.
  - in_valid held high during DRAIN: no accept, and no data is lost because the source must hold it.

Test Plan:
- Reset and idle, ROWS=4, COLS=4: drive rst_n low mid-cycle -> all outputs at reset values immediately; after release, in_ready=1, busy_o=0.
- Single vector: accept in_data={r3=4,r2=3,r1=2,r0=1} with in_last=1 at cycle 0 -> row 0 shows 1 at cycle 1, row 1 shows 2 at cycle 2, row 2 shows 3 at cycle 3, row 3 shows 4 at cycle 4, each with its valid bit for one cycle. in_ready=0 for cycles 1-7; done_o at cycle 7; vec_cnt_o=1.
- Burst of 3 contiguous vectors A, B, C, with C last: each row shows A, B, C in consecutive cycles starting at cycle 1+r. Drain lasts 7 cycles after C is accepted; vec_cnt_o=3.
- Gapped stream: in_valid pattern 1,0,1 with in_last on the third beat -> every row shows data, bubble (0, valid 0), data at its own skew offset.
- Backpressure: hold in_valid=1 during DRAIN -> no accept and no shift of new data. After done_o, the held vector is accepted in the first IDLE cycle and vec_cnt_o restarts at 1.
- Reset mid-DRAIN: assert rst_n low two cycles into DRAIN -> no done_o, delay lines zeroed, vec_cnt_o=0, FSM in IDLE.

Source files
------------

// File: rtl/syst_skew_feeder_if.sv
// Activation input handshake for the systolic skew feeder.
// The master drives a ROWS-wide vector; the slave (feeder) returns in_ready.
interface syst_skew_feeder_if #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned X_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*X_WIDTH-1:0] in_data;
    logic                    in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/syst_skew_feeder.sv
// Diagonal skew stage feeding the left column of the weight-stationary array.
// Row r is delayed r+1 cycles; after the last vector, zero bubbles drain the array.
module syst_skew_feeder #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned X_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    syst_skew_feeder_if.slave       in_if,
    output logic [ROWS*X_WIDTH-1:0] x_o,
    output logic [ROWS-1:0]         row_valid_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_WIDTH-1:0]    vec_cnt_o
);

    localparam int unsigned DRAIN_LEN = ROWS + COLS - 1;
    localparam int unsigned DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_LEN - 1);
    localparam logic          DONE_ON_ENTRY = (DRAIN_LEN == 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e                 state_q;
    logic [DW-1:0]          drain_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   ready_q;
    logic [CNT_WIDTH-1:0]   vec_q;
    logic                   accept;

    assign accept         = in_if.in_valid & ready_q;
    assign in_if.in_ready = ready_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign vec_cnt_o      = vec_q;

    // Outputs are registered alongside the state, so each is set from the transition taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            vec_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        vec_q  <= CNT_WIDTH'(1);
                        busy_q <= 1'b1;
                        if (in_if.in_last) begin
                            state_q <= DRAIN;
                            drain_q <= DRAIN_INIT;
                            ready_q <= 1'b0;
                            done_q  <= DONE_ON_ENTRY;
                        end else begin
                            state_q <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (vec_q != '1) begin
                            vec_q <= vec_q + CNT_WIDTH'(1);
                        end
                        if (in_if.in_last) begin
                            state_q <= DRAIN;
                            drain_q <= DRAIN_INIT;
                            ready_q <= 1'b0;
                            done_q  <= DONE_ON_ENTRY;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                        done_q  <= (drain_q == DW'(1));
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int unsigned DEPTH = r + 1;

        // Each stage holds {valid, data}; bubbles are all-zero.
        logic [X_WIDTH:0] stage_q [DEPTH];
        logic [X_WIDTH:0] head_d;

        assign head_d = accept ? {1'b1, in_if.in_data[r*X_WIDTH +: X_WIDTH]} : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < DEPTH; s++) begin
                    stage_q[s] <= '0;
                end
            end else begin
                stage_q[0] <= head_d;
                for (int unsigned s = 1; s < DEPTH; s++) begin
                    stage_q[s] <= stage_q[s-1];
                end
            end
        end

        assign x_o[r*X_WIDTH +: X_WIDTH] = stage_q[DEPTH-1][X_WIDTH-1:0];
        assign row_valid_o[r]            = stage_q[DEPTH-1][X_WIDTH];
    end

endmodule

// File: tb/tb_syst_skew_feeder.sv
// Directed bench for syst_skew_feeder at ROWS=4, COLS=4 (drain length 7).
// Expected lanes come from a table of accepted beats delayed r+1 cycles per row.
module tb_syst_skew_feeder;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned XW   = 8;
    localparam int unsigned CW   = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    syst_skew_feeder_if #(.ROWS(ROWS), .X_WIDTH(XW)) bus ();

    logic [ROWS*XW-1:0] x_o;
    logic [ROWS-1:0]    row_valid_o;
    logic               busy_o;
    logic               done_o;
    logic [CW-1:0]      vec_cnt_o;

    syst_skew_feeder #(
        .ROWS(ROWS), .COLS(COLS), .X_WIDTH(XW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_if(bus),
        .x_o(x_o), .row_valid_o(row_valid_o), .busy_o(busy_o),
        .done_o(done_o), .vec_cnt_o(vec_cnt_o)
    );

    int vectors = 0;
    int errors  = 0;

    // Accepted-beat table indexed by cycle within the current scenario.
    logic        bv [0:31];
    logic [31:0] bd [0:31];
    logic        bs [0:31];
    int unsigned cnt_prev;

    task automatic clear_model(input int unsigned prev);
        for (int k = 0; k < 32; k++) begin
            bv[k] = 1'b0; bd[k] = '0; bs[k] = 1'b0;
        end
        cnt_prev = prev;
    endtask

    function automatic logic [XW:0] model_lane(input int c, input int r);
        int k;
        k = c - 1 - r;
        if (k >= 0 && k < 32 && bv[k]) return {1'b1, bd[k][r*XW +: XW]};
        return '0;
    endfunction

    function automatic int unsigned model_cnt(input int c);
        int unsigned n;
        n = cnt_prev;
        for (int k = 0; k < c && k < 32; k++) begin
            if (bv[k]) n = bs[k] ? 1 : n + 1;
        end
        return n;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        bus.in_valid = v; bus.in_data = d; bus.in_last = l;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h44332211, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        vectors++;
        if ({busy_o, row_valid_o, x_o[7:0]} !== {1'b1, 4'b0001, 8'h11}) begin
            errors++; $display("FAIL reset_pre: got busy=%b rv=%b x0=%h, want 1 0001 11", busy_o, row_valid_o, x_o[7:0]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (x_o !== '0) begin errors++; $display("FAIL reset_x: got %h, want 0", x_o); end
        vectors++; if (row_valid_o !== '0) begin errors++; $display("FAIL reset_rv: got %b, want 0", row_valid_o); end
        vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy_o); end
        vectors++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, want 0", done_o); end
        vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, want 1", bus.in_ready); end
        vectors++; if (vec_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %0d, want 0", vec_cnt_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({bus.in_ready, busy_o} !== 2'b10) begin
            errors++; $display("FAIL reset_release: got ready=%b busy=%b, want 1 0", bus.in_ready, busy_o);
        end
    endtask

    task automatic test_single();
        logic rdy, bsy, dn;
        clear_model(0);
        bv[0] = 1'b1; bd[0] = 32'h04030201; bs[0] = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) drive(1'b1, 32'h04030201, 1'b1);
            else        drive(1'b0, 32'hDEADBEEF, 1'b1);
            for (int r = 0; r < ROWS; r++) begin
                vectors++;
                if ({row_valid_o[r], x_o[r*XW +: XW]} !== model_lane(c, r)) begin
                    errors++; $display("FAIL single_lane c=%0d r=%0d: got %h, want %h", c, r, {row_valid_o[r], x_o[r*XW +: XW]}, model_lane(c, r));
                end
            end
            bsy = (c >= 1 && c <= 7); rdy = !bsy; dn = (c == 7);
            vectors++;
            if ({bus.in_ready, busy_o, done_o} !== {rdy, bsy, dn}) begin
                errors++; $display("FAIL single_ctrl c=%0d: got rdy/busy/done=%b%b%b, want %b%b%b", c, bus.in_ready, busy_o, done_o, rdy, bsy, dn);
            end
            vectors++;
            if (vec_cnt_o !== CW'(model_cnt(c))) begin
                errors++; $display("FAIL single_cnt c=%0d: got %0d, want %0d", c, vec_cnt_o, model_cnt(c));
            end
            tick();
        end
    endtask

    // Three beats over cycles 0..2 (gapped when gap=1), last on cycle 2.
    task automatic test_three(input logic gap, input int unsigned prev);
        logic [31:0] beat [0:2];
        logic rdy, bsy, dn;
        beat[0] = 32'hA3A2A1A0; beat[1] = 32'hB3B2B1B0; beat[2] = 32'hC3C2C1C0;
        clear_model(prev);
        for (int k = 0; k < 3; k++) begin
            bv[k] = !(gap && k == 1); bd[k] = beat[k];
        end
        bs[0] = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            if (c < 3) begin
                if (bv[c]) drive(1'b1, beat[c], c == 2);
                else       drive(1'b0, 32'h55555555, 1'b1);
            end else begin
                drive(1'b0, '0, 1'b0);
            end
            for (int r = 0; r < ROWS; r++) begin
                vectors++;
                if ({row_valid_o[r], x_o[r*XW +: XW]} !== model_lane(c, r)) begin
                    errors++; $display("FAIL %s_lane c=%0d r=%0d: got %h, want %h", gap ? "gapped" : "burst", c, r, {row_valid_o[r], x_o[r*XW +: XW]}, model_lane(c, r));
                end
            end
            bsy = (c >= 1 && c <= 9); rdy = !(c >= 3 && c <= 9); dn = (c == 9);
            vectors++;
            if ({bus.in_ready, busy_o, done_o} !== {rdy, bsy, dn}) begin
                errors++; $display("FAIL %s_ctrl c=%0d: got rdy/busy/done=%b%b%b, want %b%b%b", gap ? "gapped" : "burst", c, bus.in_ready, busy_o, done_o, rdy, bsy, dn);
            end
            vectors++;
            if (vec_cnt_o !== CW'(model_cnt(c))) begin
                errors++; $display("FAIL %s_cnt c=%0d: got %0d, want %0d", gap ? "gapped" : "burst", c, vec_cnt_o, model_cnt(c));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic rdy, bsy, dn;
        clear_model(2);
        bv[0] = 1'b1; bd[0] = 32'h13121110; bs[0] = 1'b1;
        bv[1] = 1'b1; bd[1] = 32'h23222120;
        bv[9] = 1'b1; bd[9] = 32'h63626160; bs[9] = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            if (c == 0)      drive(1'b1, 32'h13121110, 1'b0);
            else if (c == 1) drive(1'b1, 32'h23222120, 1'b1);
            else if (c <= 9) drive(1'b1, 32'h63626160, 1'b1);
            else             drive(1'b0, '0, 1'b0);
            for (int r = 0; r < ROWS; r++) begin
                vectors++;
                if ({row_valid_o[r], x_o[r*XW +: XW]} !== model_lane(c, r)) begin
                    errors++; $display("FAIL bp_lane c=%0d r=%0d: got %h, want %h", c, r, {row_valid_o[r], x_o[r*XW +: XW]}, model_lane(c, r));
                end
            end
            bsy = (c >= 1 && c <= 8) || (c >= 10 && c <= 16);
            rdy = !((c >= 2 && c <= 8) || (c >= 10 && c <= 16));
            dn  = (c == 8) || (c == 16);
            vectors++;
            if ({bus.in_ready, busy_o, done_o} !== {rdy, bsy, dn}) begin
                errors++; $display("FAIL bp_ctrl c=%0d: got rdy/busy/done=%b%b%b, want %b%b%b", c, bus.in_ready, busy_o, done_o, rdy, bsy, dn);
            end
            vectors++;
            if (vec_cnt_o !== CW'(model_cnt(c))) begin
                errors++; $display("FAIL bp_cnt c=%0d: got %0d, want %0d", c, vec_cnt_o, model_cnt(c));
            end
            tick();
        end
    endtask

    task automatic test_reset_drain();
        drive(1'b1, 32'h0D0C0B0A, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        vectors++;
        if ({busy_o, row_valid_o, x_o[15:8]} !== {1'b1, 4'b0010, 8'h0B}) begin
            errors++; $display("FAIL rdrain_pre: got busy=%b rv=%b x1=%h, want 1 0010 0b", busy_o, row_valid_o, x_o[15:8]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({x_o, row_valid_o} !== '0) begin
            errors++; $display("FAIL rdrain_lines: got x=%h rv=%b, want 0 0", x_o, row_valid_o);
        end
        vectors++;
        if ({bus.in_ready, busy_o, done_o, vec_cnt_o} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            errors++; $display("FAIL rdrain_ctrl: got rdy=%b busy=%b done=%b cnt=%0d, want 1 0 0 0", bus.in_ready, busy_o, done_o, vec_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if ({done_o, busy_o, row_valid_o, bus.in_ready} !== {1'b0, 1'b0, 4'b0000, 1'b1}) begin
                errors++; $display("FAIL rdrain_after c=%0d: got done=%b busy=%b rv=%b rdy=%b, want 0 0 0000 1", c, done_o, busy_o, row_valid_o, bus.in_ready);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_three(1'b0, 1);
        test_three(1'b1, 3);
        test_backpressure();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
